// File: rtl/code_entry_if.sv
// Bus between the keypad/lock side and the code_entry controller.
// The controller is the slave; whatever drives bits and reads the lock is the master.
interface code_entry_if;
  logic       bit_vld;
  logic       bit_in;
  logic       clr;
  logic       enter;
  logic       led1_n;
  logic       led2_n;
  logic [3:0] code_out;
  logic       d_out;
  logic [2:0] digits;
  logic [1:0] fail_cnt;
  logic       unlocked;
  logic       short_err;
  logic       locked_out;

  modport master (
    output bit_vld, bit_in, clr, enter, led1_n, led2_n,
    input  code_out, d_out, digits, fail_cnt, unlocked, short_err, locked_out
  );

  modport slave (
    input  bit_vld, bit_in, clr, enter, led1_n, led2_n,
    output code_out, d_out, digits, fail_cnt, unlocked, short_err, locked_out
  );
endinterface

// File: rtl/code_entry.sv
// Four-bit code entry controller: collects bits, presents them to the lock with a
// confirm pulse, tracks consecutive failures and enforces a timed lockout.
module code_entry #(
  parameter int HOLD_CYC    = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 1000
) (
  input  logic            clk,
  input  logic            rst,
  code_entry_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_SUBMIT,
    S_LOCKOUT
  } state_t;

  localparam int LOCK_W = $clog2(LOCKOUT_CYC + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [2:0]        FAIL_LIM  = 3'(MAX_FAIL);

  state_t            state;
  logic [3:0]        code;
  logic [2:0]        digits;
  logic [1:0]        fail_cnt;
  logic              d_out;
  logic              unlocked;
  logic              short_err;
  logic              locked_out;
  logic [HOLD_W-1:0] hold_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic [2:0]        fail_next;
  logic              unused_led2;

  // The alarm indicator is part of the lock bus but plays no role in the decision.
  assign unused_led2 = bus.led2_n;
  assign fail_next   = {1'b0, fail_cnt} + 3'd1;

  always_ff @(posedge clk) begin
    // NOTE: every register here, including the plain counters, is cleared by the
    // synchronous reset so no output can carry stale state out of reset.
    if (rst) begin
      state      <= S_IDLE;
      code       <= 4'd0;
      digits     <= 3'd0;
      fail_cnt   <= 2'd0;
      d_out      <= 1'b0;
      unlocked   <= 1'b0;
      short_err  <= 1'b0;
      locked_out <= 1'b0;
      hold_cnt   <= '0;
      lock_cnt   <= '0;
    end else begin
      // NOTE: pulse outputs default low each cycle and are raised only by the
      // branch that owns the event, giving exactly one-cycle pulses.
      unlocked  <= 1'b0;
      short_err <= 1'b0;

      case (state)
        // IDLE and ENTRY share the same priority chain; in IDLE digits is 0,
        // so enter never submits and clr just re-clears an empty entry.
        S_IDLE, S_ENTRY: begin
          if (bus.clr) begin
            code   <= 4'd0;
            digits <= 3'd0;
            state  <= S_IDLE;
          end else if (bus.enter) begin
            if (state == S_ENTRY) begin
              if (digits == 3'd4) begin
                state    <= S_SUBMIT;
                d_out    <= 1'b1;
                hold_cnt <= '0;
              end else begin
                short_err <= 1'b1;
              end
            end
          end else if (bus.bit_vld && digits != 3'd4) begin
            code   <= {code[2:0], bus.bit_in};
            digits <= digits + 3'd1;
            state  <= S_ENTRY;
          end
        end

        S_SUBMIT: begin
          if (hold_cnt == HOLD_LAST) begin
            // Last confirm cycle: the lock's answer is only trusted here.
            d_out  <= 1'b0;
            code   <= 4'd0;
            digits <= 3'd0;
            if (!bus.led1_n) begin
              fail_cnt <= 2'd0;
              unlocked <= 1'b1;
              state    <= S_IDLE;
            end else if (fail_next >= FAIL_LIM) begin
              fail_cnt   <= FAIL_LIM[1:0];
              locked_out <= 1'b1;
              lock_cnt   <= '0;
              state      <= S_LOCKOUT;
            end else begin
              fail_cnt <= fail_next[1:0];
              state    <= S_IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        S_LOCKOUT: begin
          if (lock_cnt == LOCK_LAST) begin
            locked_out <= 1'b0;
            fail_cnt   <= 2'd0;
            state      <= S_IDLE;
          end else begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.code_out   = code;
  assign bus.d_out      = d_out;
  assign bus.digits     = digits;
  assign bus.fail_cnt   = fail_cnt;
  assign bus.unlocked   = unlocked;
  assign bus.short_err  = short_err;
  assign bus.locked_out = locked_out;

endmodule
